mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
// Memory-side responder for the CPU byte-serial RAM bus driven by the memory controller.
// Serves one byte per cycle from a byte RAM with 1-cycle registered read latency.
// Decodes a small IO window: byte TX FIFO to host, byte RX FIFO from host, status, halt.
// Back-pressures the controller via rdy_out, which feeds its rdy_in, when the TX FIFO is full.
// PARAMETERS
// RAM_AW     17            RAM address bits; RAM depth = 2**RAM_AW bytes
// IO_BASE    32'h0003_0000 base of IO window; IO selected when mem_a[31:16]==IO_BASE[31:16]
// FIFO_LOG2  4             log2 depth of each of TX and RX FIFOs
// PORTS
// clk         in   1  single clock, all state on posedge
// rst         in   1  asynchronous, active-low reset
// mem_a       in   32 byte address from controller
// mem_wr      in   1  1 = write byte mem_dout to mem_a; 0 = read mem_a
// mem_dout    in   8  write data from controller
// mem_din     out  8  read data to controller, valid 1 cycle after address
// rdy_out     out  1  1 = request accepted this cycle (to controller rdy_in)
// io_tx_data  out  8  byte to host
// io_tx_valid out  1  TX head valid
// io_tx_ready in   1  host accepts io_tx_data on valid&&ready
// io_rx_data  in   8  byte from host
// io_rx_valid in   1  host offers io_rx_data
// io_rx_ready out  1  RX FIFO not full
// sim_halt    out  1  sticky halt request
// BEHAVIOUR
// - Reset (rst=0, async): mem_din=8'h00, sim_halt=0, both FIFOs empty (ptrs/counts 0),
//   io_tx_valid=0, io_rx_ready=1, rdy_out=1. RAM contents not reset.
// - rdy_out = (tx_count != 2**FIFO_LOG2), combinational. When rdy_out=0 the request in that
//   cycle is dropped: no RAM write, no FIFO push/pop, mem_din holds.
// - Decode: io_sel = (mem_a[31:16]==IO_BASE[31:16]); RAM uses mem_a[RAM_AW-1:0]; addresses
//   outside IO and above RAM alias into RAM.
// - RAM read: posedge with rdy_out&&!mem_wr&&!io_sel -> mem_din <= ram[a]. Latency 1.
// - RAM write: posedge with rdy_out&&mem_wr&&!io_sel -> ram[a] <= mem_dout; mem_din holds.
// - IO offset = mem_a[2:0]:
//   off 0 write: push mem_dout to TX. off 0 read: mem_din <= RX head and pop; RX empty -> 8'h00, no pop.
//   off 4 read: mem_din <= {6'b0, ~rdy_out, rx_nonempty}. off 4 write: sim_halt <= 1 (sticky to reset).
//   other offsets: read returns 8'h00, write ignored.
// - TX FIFO: io_tx_valid = tx_count!=0; io_tx_data = head (combinational from storage).
//   Pop on io_tx_valid&&io_tx_ready. Same-cycle push+pop: both occur, count unchanged.
// - RX FIFO: io_rx_ready = rx_count!=2**FIFO_LOG2; push on io_rx_valid&&io_rx_ready.
//   Same-cycle CPU pop + host push: both occur; pop returns old head even if count was 1.
//   Push while empty+pop same cycle: pop sees empty -> 8'h00, pushed byte retained.
// - Pointers are FIFO_LOG2 bits and wrap modulo depth; counts are FIFO_LOG2+1 bits.
// - Reset asserted mid-burst: FIFO contents discarded, in-flight read data lost, mem_din=0.
// - No internal FSM beyond FIFO control; controller sequencing (4 byte-cycles/word) is
//   transparent: each cycle is an independent byte transaction.
// TESTING
// - Write 8'hA5 @0x100, next cycle read 0x100 -> mem_din=8'hA5 exactly 1 cycle after read addr.
// - Word burst: writes 0x78,0x56,0x34,0x12 @0x200..0x203, 4 reads -> bytes in order, 1-cycle lag.
// - io_tx_ready=0, 16 writes to 0x30000 -> rdy_out=0 after 16th; 17th write dropped;
//   raise io_tx_ready -> 16 bytes out in order, rdy_out back to 1 after first pop.
// - Host pushes 0x41,0x42; read 0x30004 -> 8'h01; read 0x30000 twice -> 0x41,0x42; third -> 0x00.
// - Write to 0x30004 -> sim_halt=1 next cycle and holds; rst low mid-stream -> sim_halt=0,
//   io_tx_valid=0, mem_din=0 immediately.
// - Simultaneous TX push+pop at count 16 not possible (rdy_out=0); at count 5 -> count stays 5.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the byte-serial CPU RAM bus.
// Each cycle is one independent byte transaction. The RAM has a registered
// read latency of one cycle. A small IO window holds a TX byte FIFO to the
// host, an RX byte FIFO from the host, a status byte and a sticky halt flag.
//
// Ports:
//   clk, rst             clock (posedge) / async active-low reset
//   mem_a, mem_wr,       byte request from the controller
//   mem_dout
//   mem_din              read data, valid one cycle after the address
//   rdy_out              request accepted this cycle (low while TX is full)
//   io_tx_*              TX FIFO head to host (valid/ready)
//   io_rx_*              RX FIFO input from host (valid/ready)
//   sim_halt             sticky halt request

// Byte FIFO: power-of-two depth, wrapping pointers, count one bit wider.
// Callers never push while full or pop while empty.
module mem_io_fifo #(
  parameter int LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LOG2:0] count
);
  localparam int DEPTH = 1 << LOG2;

  logic [DEPTH-1:0][7:0] mem;
  logic [LOG2-1:0]       wp, rp;

  assign head = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + LOG2'(1);
      end
      if (pop) rp <= rp + LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (LOG2+1)'(1);
        2'b01:   count <= count - (LOG2+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module mem_io_responder #(
  parameter int          RAM_AW    = 17,
  parameter logic [31:0] IO_BASE   = 32'h0003_0000,
  parameter int          FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        sim_halt
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL = (FIFO_LOG2+1)'(DEPTH);

  logic [FIFO_LOG2:0] tx_count, rx_count;
  logic [7:0]         rx_head, rdata;
  logic               io_sel, rd, wr, rx_ne;
  logic               tx_push, tx_pop, rx_push, rx_pop;
  logic [2:0]         off;
  logic [RAM_AW-1:0]  ram_a;

  logic [7:0] ram [0:(1<<RAM_AW)-1];

  // A full TX FIFO stalls the whole bus, RAM traffic included.
  assign rdy_out     = tx_count != FULL;
  assign io_tx_valid = tx_count != '0;
  assign io_rx_ready = rx_count != FULL;
  assign rx_ne       = rx_count != '0;

  assign io_sel = mem_a[31:16] == IO_BASE[31:16];
  assign off    = mem_a[2:0];
  assign ram_a  = mem_a[RAM_AW-1:0];
  assign rd     = rdy_out & ~mem_wr;
  assign wr     = rdy_out &  mem_wr;

  assign tx_push = wr & io_sel & (off == 3'd0);
  assign tx_pop  = io_tx_valid & io_tx_ready;
  assign rx_pop  = rd & io_sel & (off == 3'd0) & rx_ne;
  assign rx_push = io_rx_valid & io_rx_ready;

  mem_io_fifo #(.LOG2(FIFO_LOG2)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(mem_dout),
    .pop(tx_pop), .head(io_tx_data), .count(tx_count)
  );

  // A CPU pop and host push in the same cycle both land; the pop reads the
  // pre-edge head, so a push into an empty FIFO is never returned early.
  mem_io_fifo #(.LOG2(FIFO_LOG2)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(io_rx_data),
    .pop(rx_pop), .head(rx_head), .count(rx_count)
  );

  always_comb begin
    rdata = 8'h00;
    if (!io_sel) rdata = ram[ram_a];
    else begin
      case (off)
        3'd0:    rdata = rx_ne ? rx_head : 8'h00;
        // bit1 is the stall flag; an accepted read always sees it clear.
        3'd4:    rdata = {6'b0, ~rdy_out, rx_ne};
        default: rdata = 8'h00;
      endcase
    end
  end

  // RAM array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr && !io_sel) ram[ram_a] <= mem_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din  <= 8'h00;
      sim_halt <= 1'b0;
    end else begin
      if (rd) mem_din <= rdata;
      if (wr && io_sel && off == 3'd4) sim_halt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout, mem_din;
  logic        rdy_out;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid, io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid, io_rx_ready;
  logic        sim_halt;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .rdy_out(rdy_out), .io_tx_data(io_tx_data),
    .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready), .io_rx_data(io_rx_data),
    .io_rx_valid(io_rx_valid), .io_rx_ready(io_rx_ready), .sim_halt(sim_halt)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed RAM map plus two queues.
  logic [7:0] m_ram [int];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] m_din;
  bit         din_known, m_halt;

  task automatic model_reset();
    tx_q.delete(); rx_q.delete();
    m_din = 8'h00; din_known = 1; m_halt = 0;
  endtask

  task automatic model_edge();
    bit acc, io, txpop, rxpush, rxne;
    int k;
    logic [2:0] o;
    acc    = tx_q.size() != 16;
    io     = mem_a[31:16] == 16'h0003;
    o      = mem_a[2:0];
    k      = int'(mem_a[16:0]);
    txpop  = tx_q.size() != 0 && io_tx_ready;
    rxpush = io_rx_valid && rx_q.size() != 16;
    rxne   = rx_q.size() != 0;
    if (txpop) void'(tx_q.pop_front());
    if (acc) begin
      if (mem_wr) begin
        if (!io) m_ram[k] = mem_dout;
        else if (o == 0) tx_q.push_back(mem_dout);
        else if (o == 4) m_halt = 1;
      end else begin
        din_known = 1;
        if (!io) begin
          if (m_ram.exists(k)) m_din = m_ram[k];
          else din_known = 0;
        end else if (o == 0) m_din = rxne ? rx_q.pop_front() : 8'h00;
        else if (o == 4) m_din = {7'b0, rxne};
        else m_din = 8'h00;
      end
    end
    if (rxpush) rx_q.push_back(io_rx_data);
  endtask

  task automatic check_all();
    chk("rdy_out", rdy_out, tx_q.size() != 16);
    chk("tx_valid", io_tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("tx_data", io_tx_data, tx_q[0]);
    chk("rx_ready", io_rx_ready, rx_q.size() != 16);
    chk("sim_halt", sim_halt, m_halt);
    if (din_known) chk("mem_din", mem_din, m_din);
  endtask

  // Inputs are driven at negedge; the model advances at posedge; outputs
  // are checked at the following negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    mem_a = a; mem_wr = w; mem_dout = d;
    step();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_din"}, mem_din, 8'h00);
    chk({tag, "_halt"}, sim_halt, 1'b0);
    chk({tag, "_txv"}, io_tx_valid, 1'b0);
    chk({tag, "_rxr"}, io_rx_ready, 1'b1);
    chk({tag, "_rdy"}, rdy_out, 1'b1);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst = 1'b0; mem_a = '0; mem_wr = 0; mem_dout = '0;
    io_tx_ready = 0; io_rx_valid = 0; io_rx_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_check("rst0");
    rst = 1'b1;

    // single byte write then read, one-cycle latency
    bus(32'h100, 1, 8'hA5);
    bus(32'h100, 0, 8'h00);
    chk("rd_a5", mem_din, 8'hA5);

    // little-endian word burst
    bus(32'h200, 1, 8'h78); bus(32'h201, 1, 8'h56);
    bus(32'h202, 1, 8'h34); bus(32'h203, 1, 8'h12);
    bus(32'h200, 0, 0); chk("burst0", mem_din, 8'h78);
    bus(32'h201, 0, 0); chk("burst1", mem_din, 8'h56);
    bus(32'h202, 0, 0); chk("burst2", mem_din, 8'h34);
    bus(32'h203, 0, 0); chk("burst3", mem_din, 8'h12);

    // fill TX, overflow write dropped, drain in order
    for (int i = 0; i < 16; i++) bus(32'h30000, 1, 8'(8'h60 + i));
    chk("tx_full_rdy", rdy_out, 1'b0);
    bus(32'h30000, 1, 8'hEE);
    bus(32'h100, 0, 0);
    chk("stall_din_hold", mem_din, 8'h12);
    mem_a = 32'h400; mem_wr = 0;
    io_tx_ready = 1;
    chk("tx_head0", io_tx_data, 8'h60);
    step();
    chk("rdy_after_pop", rdy_out, 1'b1);
    n = 1;
    while (io_tx_valid && n < 40) begin
      chk("tx_order", io_tx_data, 8'(8'h60 + n));
      step(); n++;
    end
    chk("tx_drained", n, 16);
    io_tx_ready = 0;

    // host RX path and status
    io_rx_valid = 1; io_rx_data = 8'h41; step();
    io_rx_data = 8'h42; step();
    io_rx_valid = 0;
    bus(32'h30004, 0, 0); chk("status", mem_din, 8'h01);
    bus(32'h30000, 0, 0); chk("rx0", mem_din, 8'h41);
    bus(32'h30000, 0, 0); chk("rx1", mem_din, 8'h42);
    bus(32'h30000, 0, 0); chk("rx_empty", mem_din, 8'h00);
    bus(32'h30004, 0, 0); chk("status_empty", mem_din, 8'h00);

    // push into empty RX while CPU pops: pop sees empty, byte kept
    io_rx_valid = 1; io_rx_data = 8'h77;
    bus(32'h30000, 0, 0); chk("rx_pushpop_empty", mem_din, 8'h00);
    io_rx_valid = 0;
    bus(32'h30000, 0, 0); chk("rx_kept", mem_din, 8'h77);

    // TX push+pop at count 5 keeps count 5
    for (int i = 0; i < 5; i++) bus(32'h30000, 1, 8'(8'hA0 + i));
    io_tx_ready = 1; bus(32'h30000, 1, 8'hA5);
    io_tx_ready = 0; mem_wr = 0; mem_a = 32'h400;
    io_tx_ready = 1; n = 0;
    while (io_tx_valid && n < 40) begin step(); n++; end
    chk("tx_cnt5", n, 5);
    io_tx_ready = 0;

    // other IO offsets
    bus(32'h30002, 1, 8'h33);
    bus(32'h30002, 0, 0); chk("io_off2", mem_din, 8'h00);

    // halt
    bus(32'h30004, 1, 8'h00); chk("halt_set", sim_halt, 1'b1);
    bus(32'h100, 0, 0); chk("halt_hold", sim_halt, 1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      io_tx_ready = ($urandom_range(0, 3) != 0) && (c % 400 > 120);
      io_rx_valid = $urandom_range(0, 1);
      io_rx_data  = 8'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        a = {$urandom, 12'h0} | 32'h400 | 32'($urandom_range(0, 15));
        if (a[31:16] == 16'h0003) a[31:16] = 16'h0013;
      end else a = 32'h30000 | 32'($urandom_range(0, 7));
      if (a[31:16] == 16'h0003 && a[2:0] == 3'd0 && $urandom_range(0, 1))
        a[2:0] = 3'd0;
      bus(a, $urandom_range(0, 1), 8'($urandom));
    end

    // reset mid-stream with TX data pending
    io_tx_ready = 0;
    bus(32'h30000, 1, 8'h11);
    bus(32'h30004, 1, 8'h00);
    bus(32'h100, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    reset_check("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    bus(32'h30000, 0, 0); chk("post_rst_rx", mem_din, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
